// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Multicycle instruction-fetch stage. Owns the program counter,
//               drives the instruction-memory read address, captures the
//               returned word and offers it downstream on a valid/ready
//               handshake. Accepts PC redirects and traps misaligned targets.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   i_clk             in   1   system clock, rising edge
//   i_reset_n         in   1   asynchronous active-low reset
//   o_imem_address    out  32  imem read address (always the current PC)
//   i_imem_data_out   in   32  imem read data, valid one cycle after address
//   i_redirect_valid  in   1   single-cycle redirect request
//   i_redirect_pc     in   32  redirect target
//   o_instr           out  32  captured instruction word
//   o_instr_pc        out  32  address o_instr was fetched from
//   o_instr_pc_plus4  out  32  o_instr_pc + 4 (wraps)
//   o_instr_valid     out  1   o_instr / o_instr_pc hold a live instruction
//   i_instr_ready     in   1   downstream accepts o_instr this cycle
//   o_fetch_fault     out  1   sticky misaligned-redirect flag
//   o_fault_pc        out  32  offending redirect target
//   o_fetch_count     out  32  accepted-instruction count (wraps)
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  output logic [31:0] o_imem_address,
  input  logic [31:0] i_imem_data_out,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic [31:0] o_instr_pc_plus4,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic        o_fetch_fault,
  output logic [31:0] o_fault_pc,
  output logic [31:0] o_fetch_count
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_fault_pc;
  logic [31:0] r_fetch_count;

  logic        w_redir_ok;
  logic        w_redir_bad;
  logic        w_accept;
  logic        w_capture;

  // Next-state and control decode. A redirect outranks the handshake, and
  // FAULT is a sink that ignores everything except reset.
  always_comb begin
    w_state_next = r_state;
    w_redir_ok   = 1'b0;
    w_redir_bad  = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;

    if ((r_state != ST_FAULT) && i_redirect_valid) begin
      if (i_redirect_pc[1:0] == 2'b00) begin
        w_redir_ok = 1'b1;
      end else begin
        w_redir_bad = 1'b1;
      end
    end

    case (r_state)
      ST_ISSUE: w_state_next = ST_WAIT;
      ST_WAIT: begin
        // Data for a PC that is being redirected away from is discarded.
        w_capture    = !i_redirect_valid;
        w_state_next = ST_VALID;
      end
      ST_VALID: begin
        w_accept = i_instr_ready && !i_redirect_valid;
        if (i_instr_ready) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_FAULT: w_state_next = ST_FAULT;
    endcase

    if (w_redir_bad) begin
      w_state_next = ST_FAULT;
    end else if (w_redir_ok) begin
      w_state_next = ST_ISSUE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_ISSUE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_fault_pc    <= '0;
      r_fetch_count <= '0;
    end else begin
      if (w_redir_ok) begin
        r_pc <= i_redirect_pc;
      end else if (w_accept) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_accept) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_capture) begin
        r_instr    <= i_imem_data_out;
        r_instr_pc <= r_pc;
      end
      if (w_redir_bad) begin
        r_fault_pc <= i_redirect_pc;
      end
    end
  end

  assign o_imem_address   = r_pc;
  assign o_instr          = r_instr;
  assign o_instr_pc       = r_instr_pc;
  assign o_instr_pc_plus4 = r_instr_pc + 32'd4;
  assign o_instr_valid    = (r_state == ST_VALID);
  assign o_fetch_fault    = (r_state == ST_FAULT);
  assign o_fault_pc       = r_fault_pc;
  assign o_fetch_count    = r_fetch_count;

endmodule
`default_nettype wire
